// File: rtl/tt_um_hoene_host_transmitter_pkg.sv
// Shared definitions for the host Manchester transmitter and the receive-chain models.
// Holds the state encoding, the minimum half-period and the bit-level line convention.
package tt_um_hoene_host_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  localparam int MIN_HALF_PERIOD = 2;

  // Line level of the first half of a '1' bit; a '0' bit is the mirror image.
  localparam logic ONE_FIRST_LEVEL = 1'b1;

  function automatic logic manchester_level(input logic bit_value, input logic second_half);
    return (bit_value ? ONE_FIRST_LEVEL : ~ONE_FIRST_LEVEL) ^ second_half;
  endfunction

endpackage

// File: rtl/tt_um_hoene_halfbit_timer.sv
// Half-bit timer: counts 0..hp-1 and flags the last clock of each half plus which half is active.
module tt_um_hoene_halfbit_timer #(
  parameter int HP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [HP_WIDTH-1:0] hp,
  output logic                half_end,
  output logic                phase
);

  logic [HP_WIDTH-1:0] count_reg;
  logic                phase_reg;

  assign half_end = (count_reg == hp - 1'b1);
  assign phase    = phase_reg;

  // restart wins over half_end so a new section always starts in its first half.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else if (half_end) begin
      count_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_hoene_host_transmitter.sv
// Host-side Manchester transmitter: one-entry word buffer, framing FSM and MSB-first shifter.
// Frames are a low lead, back-to-back words, then a low gap; all outputs are registered.
module tt_um_hoene_host_transmitter
  import tt_um_hoene_host_transmitter_pkg::*;
#(
  parameter int WORD_BITS   = 32,
  parameter int LEAD_HALVES = 2,
  parameter int GAP_BITS    = 4,
  parameter int HP_WIDTH    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HP_WIDTH-1:0]  half_period,
  input  logic [WORD_BITS-1:0] in_word,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_data,
  output logic                 out_enable,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun
);

  localparam int BIT_W    = $clog2(WORD_BITS);
  localparam int HALVES_W = 8;

  tx_state_t              state_reg;
  logic [HP_WIDTH-1:0]    hp_reg;
  logic [HP_WIDTH-1:0]    hp_eff;
  logic                   hold_valid_reg;
  logic [WORD_BITS-1:0]   hold_word_reg;
  logic                   hold_last_reg;
  logic [WORD_BITS-1:0]   shift_reg;
  logic                   last_reg;
  logic [BIT_W-1:0]       bit_cnt_reg;
  logic [HALVES_W-1:0]    halves_reg;
  logic                   in_ready_reg;
  logic                   out_data_reg;
  logic                   out_enable_reg;
  logic                   busy_reg;
  logic                   frame_done_reg;
  logic                   underrun_reg;

  logic half_end;
  logic phase;
  logic take;
  logic lead_end;
  logic word_end;
  logic chain;
  logic gap_end;
  logic unload;
  logic hold_valid_next;

  assign hp_eff = (half_period < HP_WIDTH'(MIN_HALF_PERIOD)) ? HP_WIDTH'(MIN_HALF_PERIOD)
                                                             : half_period;

  assign take     = in_valid && in_ready_reg;
  assign lead_end = (state_reg == LEAD) && half_end && (halves_reg == HALVES_W'(LEAD_HALVES - 1));
  assign word_end = (state_reg == SEND) && half_end && phase
                    && (bit_cnt_reg == BIT_W'(WORD_BITS - 1));
  assign chain    = word_end && !last_reg && hold_valid_reg;
  assign gap_end  = (state_reg == GAP) && half_end && (halves_reg == HALVES_W'(2 * GAP_BITS - 1));
  assign unload   = lead_end || chain;
  assign hold_valid_next = take || (hold_valid_reg && !unload);

  tt_um_hoene_halfbit_timer #(.HP_WIDTH(HP_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  ((state_reg == IDLE) || lead_end),
    .hp       (hp_reg),
    .half_end (half_end),
    .phase    (phase)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hp_reg         <= HP_WIDTH'(MIN_HALF_PERIOD);
      hold_valid_reg <= 1'b0;
      hold_word_reg  <= '0;
      hold_last_reg  <= 1'b0;
      shift_reg      <= '0;
      last_reg       <= 1'b0;
      bit_cnt_reg    <= '0;
      halves_reg     <= '0;
      in_ready_reg   <= 1'b1;
      out_data_reg   <= 1'b0;
      out_enable_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      hold_valid_reg <= hold_valid_next;
      in_ready_reg   <= !hold_valid_next;
      busy_reg       <= hold_valid_next || ((state_reg != IDLE) && !gap_end);
      if (take) begin
        hold_word_reg <= in_word;
        hold_last_reg <= in_last;
      end
      case (state_reg)
        IDLE: begin
          if (hold_valid_reg) begin
            state_reg      <= LEAD;
            hp_reg         <= hp_eff;
            halves_reg     <= '0;
            out_enable_reg <= 1'b1;
            out_data_reg   <= 1'b0;
          end
        end
        LEAD: begin
          if (half_end) begin
            halves_reg <= halves_reg + 1'b1;
            if (lead_end) begin
              state_reg    <= SEND;
              shift_reg    <= hold_word_reg;
              last_reg     <= hold_last_reg;
              bit_cnt_reg  <= '0;
              out_data_reg <= manchester_level(hold_word_reg[WORD_BITS-1], 1'b0);
            end
          end
        end
        SEND: begin
          if (half_end) begin
            if (!phase) begin
              out_data_reg <= manchester_level(shift_reg[WORD_BITS-1], 1'b1);
            end else if (!word_end) begin
              shift_reg    <= shift_reg << 1;
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              out_data_reg <= manchester_level(shift_reg[WORD_BITS-2], 1'b0);
            end else if (chain) begin
              shift_reg    <= hold_word_reg;
              last_reg     <= hold_last_reg;
              bit_cnt_reg  <= '0;
              out_data_reg <= manchester_level(hold_word_reg[WORD_BITS-1], 1'b0);
            end else begin
              // Either the frame is complete or the host failed to supply the next word.
              underrun_reg <= !last_reg;
              state_reg    <= GAP;
              halves_reg   <= '0;
              out_data_reg <= 1'b0;
            end
          end
        end
        GAP: begin
          if (half_end) begin
            halves_reg <= halves_reg + 1'b1;
            if (gap_end) begin
              frame_done_reg <= 1'b1;
              state_reg      <= IDLE;
              out_enable_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_data   = out_data_reg;
  assign out_enable = out_enable_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_tt_um_hoene_host_transmitter.sv
// Self-checking bench: captures whole frames and compares them with a waveform built from the framing rules.
module tb_tt_um_hoene_host_transmitter;

  localparam int WB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    half_period = 6'd4;
  logic [WB-1:0] in_word = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, out_data, out_enable, busy, frame_done, underrun;

  int errors = 0;
  int checks = 0;

  logic          cap_data[$];
  logic          exp_data[$];
  logic [WB-1:0] exp_words[$];
  int cap_fd, cap_ur, cap_both, cap_wait;
  logic cap_ok;

  always #5 clk = ~clk;

  tt_um_hoene_host_transmitter dut (
    .clk(clk), .rst_n(rst_n), .half_period(half_period), .in_word(in_word),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_enable(out_enable), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  task automatic push_word(input logic [WB-1:0] w, input logic l);
    int n = 0;
    @(negedge clk);
    in_word = w; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Records out_data on every cycle out_enable is high, plus pulse counts up to the falling sample.
  task automatic capture();
    int w = 0;
    cap_data.delete();
    cap_fd = 0; cap_ur = 0; cap_both = 0; cap_ok = 1'b1;
    @(negedge clk);
    while (!out_enable && w < 3000) begin
      @(negedge clk);
      w++;
    end
    cap_wait = w;
    if (!out_enable) begin
      cap_ok = 1'b0;
      return;
    end
    while (out_enable && cap_data.size() < 20000) begin
      cap_data.push_back(out_data);
      cap_fd += int'(frame_done);
      cap_ur += int'(underrun);
      cap_both += int'(frame_done && underrun);
      @(negedge clk);
    end
    cap_fd += int'(frame_done);
    cap_ur += int'(underrun);
    cap_both += int'(frame_done && underrun);
  endtask

  task automatic build_expected(input int hp_in);
    int hp;
    hp = (hp_in < 2) ? 2 : hp_in;
    exp_data.delete();
    repeat (2 * hp) exp_data.push_back(1'b0);
    foreach (exp_words[j]) begin
      for (int k = WB - 1; k >= 0; k--) begin
        repeat (hp) exp_data.push_back(exp_words[j][k]);
        repeat (hp) exp_data.push_back(!exp_words[j][k]);
      end
    end
    repeat (8 * hp) exp_data.push_back(1'b0);
  endtask

  task automatic check_frame(input string name, input int hp_in, input int exp_ur);
    int bad = 0;
    int first_bad = -1;
    build_expected(hp_in);
    checks++;
    if (!cap_ok) begin
      errors++;
      $display("FAIL %s_start: out_enable never rose, required a frame", name);
      return;
    end
    checks++;
    if (cap_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s_length: got %0d clocks, required %0d", name, cap_data.size(), exp_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
      if (cap_data[i] !== exp_data[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_waveform: %0d wrong clocks, first at %0d got %0b required %0b",
               name, bad, first_bad, cap_data[first_bad], exp_data[first_bad]);
    end
    checks++;
    if (cap_fd != 1) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d pulses, required 1", name, cap_fd);
    end
    checks++;
    if (cap_ur != exp_ur) begin
      errors++;
      $display("FAIL %s_underrun: got %0d pulses, required %0d", name, cap_ur, exp_ur);
    end
    checks++;
    if (cap_both != 0) begin
      errors++;
      $display("FAIL %s_pulse_overlap: got %0d shared cycles, required 0", name, cap_both);
    end
    $display("frame %s: hp=%0d words=%0d clocks=%0d", name, hp_in, exp_words.size(), cap_data.size());
  endtask

  task automatic check_idle_outputs(input string name);
    logic [5:0] got;
    got = {in_ready, out_data, out_enable, busy, frame_done, underrun};
    checks++;
    if (got !== 6'b100000) begin
      errors++;
      $display("FAIL %s: {in_ready,out_data,out_enable,busy,frame_done,underrun}=%b, required 100000",
               name, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic send_frame(input string name, input int hp_in, input logic final_last);
    half_period = 6'(hp_in);
    fork
      begin
        foreach (exp_words[j]) push_word(exp_words[j], (j == exp_words.size() - 1) ? final_last : 1'b0);
      end
      capture();
    join
    check_frame(name, hp_in, final_last ? 0 : 1);
  endtask

  task automatic test_single_word();
    exp_words = '{32'h8000_0001};
    send_frame("single", 4, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_words = '{32'hFFFF_FFFF, 32'h0000_0000};
    send_frame("back_to_back", 3, 1'b1);
  endtask

  task automatic test_underrun();
    exp_words = '{WB'($urandom)};
    send_frame("underrun", 2, 1'b0);
  endtask

  task automatic test_small_half_period();
    exp_words = '{WB'($urandom)};
    send_frame("hp0", 0, 1'b1);
    exp_words = '{WB'($urandom), WB'($urandom)};
    send_frame("hp1", 1, 1'b1);
  endtask

  task automatic test_half_period_change();
    exp_words = '{WB'($urandom)};
    half_period = 6'd5;
    fork
      push_word(exp_words[0], 1'b1);
      capture();
      begin
        repeat (60) @(negedge clk);
        half_period = 6'd10;
      end
    join
    check_frame("hp_change", 5, 0);
    exp_words = '{WB'($urandom)};
    send_frame("hp_next", 10, 1'b1);
  endtask

  task automatic test_gap_boundary();
    logic [WB-1:0] wa, wb;
    wa = WB'($urandom); wb = WB'($urandom);
    half_period = 6'd3;
    fork
      begin
        push_word(wa, 1'b1);
        repeat (3 * (2 + 64) + 6) @(negedge clk);
        push_word(wb, 1'b1);
      end
      begin
        capture();
        exp_words = '{wa};
        check_frame("gap_first", 3, 0);
        capture();
        checks++;
        if (cap_wait != 0) begin
          errors++;
          $display("FAIL gap_restart: next frame began %0d cycles late, required 0", cap_wait);
        end
        exp_words = '{wb};
        check_frame("gap_second", 3, 0);
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    half_period = 6'd3;
    push_word(WB'($urandom), 1'b0);
    push_word(WB'($urandom), 1'b1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset_mid_send");
    repeat (5) @(negedge clk);
    check_idle_outputs("reset_buffer_discarded");
    exp_words = '{WB'($urandom)};
    send_frame("after_reset", 3, 1'b1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(3, 1));
      exp_words.delete();
      for (int j = 0; j < n; j++) exp_words.push_back(WB'($urandom));
      send_frame($sformatf("random%0d", f), int'($urandom_range(7, 0)), 1'b1);
    end
  endtask

  // Independent receiver model: sample mid-half and rebuild each word from the line.
  task automatic test_loopback();
    int hp, base, t, dec_err;
    logic a, b;
    logic [WB-1:0] got;
    hp = int'($urandom_range(6, 2));
    exp_words = '{32'h1234_5678, 32'h0ABC_DEF0, 32'h3FF0_03FF};
    send_frame("loopback", hp, 1'b1);
    dec_err = 0;
    base = 2 * hp;
    for (int j = 0; j < 3; j++) begin
      got = '0;
      for (int k = 0; k < WB; k++) begin
        t = base + (j * WB + k) * 2 * hp + hp / 2;
        a = (t < cap_data.size()) ? cap_data[t] : 1'bx;
        b = (t + hp < cap_data.size()) ? cap_data[t + hp] : 1'bx;
        if (a === b) dec_err++;
        got = {got[WB-2:0], a};
      end
      checks++;
      if (got !== exp_words[j]) begin
        errors++;
        $display("FAIL loopback_word%0d: decoded %h, required %h", j, got, exp_words[j]);
      end
    end
    checks++;
    if (dec_err != 0) begin
      errors++;
      $display("FAIL loopback_decode_error: %0d bits without mid-bit transition, required 0", dec_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_small_half_period();
    test_half_period_change();
    test_gap_boundary();
    test_reset_mid_frame();
    test_random_frames();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
